// File: rtl/spram_16kx16.sv
// spram_16kx16: behavioural iCE40 UltraPlus single-port RAM, 2**ADDR_W x DATA_W, nibble write masks, 1-cycle read.
// Define SPRAM_LOWPOWER_EN to honour standby/sleep/poweroff; otherwise those ports are ignored.
module spram_16kx16_lane #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              zero,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        din,
  output logic [3:0]        dout
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [3:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      // power-down loses the whole array in one cycle
      if (clear)
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      if (zero)       dout <= '0;
      else if (rd_en) dout <= mem[address];
      if (wr_en)      mem[address] <= din;
    end
  end
endmodule

module spram_16kx16 #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic                wren,
  input  logic [DATA_W/4-1:0] maskwren,
  input  logic [DATA_W-1:0]   datain,
  input  logic                standby,
  input  logic                sleep,
  input  logic                poweroff,
  output logic [DATA_W-1:0]   dataout
);
  localparam int NUM_LANES = DATA_W / 4;

  logic lp_off, lp_slp, lp_stb;
`ifdef SPRAM_LOWPOWER_EN
  assign lp_off = ~poweroff;
  assign lp_slp = sleep;
  assign lp_stb = standby;
`else
  assign lp_off = 1'b0;
  assign lp_slp = 1'b0;
  assign lp_stb = 1'b0;
  logic unused_lp;
  assign unused_lp = &{standby, sleep, poweroff};
`endif

  logic en, rd_en;
  assign en    = chipselect & ~lp_stb & ~lp_slp & ~lp_off;
  assign rd_en = en & ~wren;

  logic [NUM_LANES-1:0][3:0] din_l, dout_l;
  assign din_l   = datain;
  assign dataout = dout_l;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    spram_16kx16_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (lp_off),
      .zero   (lp_off | lp_slp),
      .rd_en  (rd_en),
      .wr_en  (en & wren & maskwren[g]),
      .address(address),
      .din    (din_l[g]),
      .dout   (dout_l[g])
    );
  end
endmodule

// File: tb/tb_spram_16kx16.sv
// Directed bench for spram_16kx16: two banks, scoreboard of expected dataout per cycle.
module tb_spram_16kx16;
  localparam int AW = 14, DW = 16, MW = 4, DEPTH = 2 ** AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic [1:0]    cs = '0;
  logic [AW-1:0] address = '0;
  logic          wren = 1'b0;
  logic [MW-1:0] mask = '0;
  logic [DW-1:0] din = '0;
  logic          standby = 1'b0, sleep = 1'b0, poweroff = 1'b1;
  logic [DW-1:0] dout0, dout1;

  spram_16kx16 u_bank0 (.clk(clk), .rst(rst), .chipselect(cs[0]), .address(address), .wren(wren),
    .maskwren(mask), .datain(din), .standby(standby), .sleep(sleep), .poweroff(poweroff), .dataout(dout0));
  spram_16kx16 u_bank1 (.clk(clk), .rst(rst), .chipselect(cs[1]), .address(address), .wren(wren),
    .maskwren(mask), .datain(din), .standby(standby), .sleep(sleep), .poweroff(poweroff), .dataout(dout1));

  logic [DW-1:0] mdl [2][DEPTH];
  logic [DW-1:0] dmdl [2];

  typedef struct { string tag; logic [DW-1:0] e0; logic [DW-1:0] e1; } exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0;

  // one clock: update reference model, push expectation, then compare after the edge
  task automatic step(input string tag);
    exp_t e, g;
    bit off, slp, stb;
    off = 0; slp = 0; stb = 0;
`ifdef SPRAM_LOWPOWER_EN
    off = !poweroff; slp = sleep; stb = standby;
`endif
    for (int b = 0; b < 2; b++) begin
      if (rst) dmdl[b] = '0;
      else if (off) begin
        dmdl[b] = '0;
        for (int i = 0; i < DEPTH; i++) mdl[b][i] = '0;
      end else if (slp) dmdl[b] = '0;
      else if (stb || !cs[b]) ;
      else if (wren) begin
        for (int n = 0; n < MW; n++)
          if (mask[n]) mdl[b][address][4*n +: 4] = din[4*n +: 4];
      end else dmdl[b] = mdl[b][address];
    end
    e.tag = tag; e.e0 = dmdl[0]; e.e1 = dmdl[1];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    checks++;
    assert (dout0 === g.e0) else begin
      errors++; $error("FAIL %s bank0 dataout=%h expected=%h", g.tag, dout0, g.e0);
    end
    checks++;
    assert (dout1 === g.e1) else begin
      errors++; $error("FAIL %s bank1 dataout=%h expected=%h", g.tag, dout1, g.e1);
    end
  endtask

  task automatic op(input logic [1:0] c, input logic w, input logic [AW-1:0] a,
                    input logic [MW-1:0] m, input logic [DW-1:0] d, input string tag);
    cs = c; wren = w; address = a; mask = m; din = d;
    step(tag);
  endtask

  task automatic expect_const(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s dataout=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      dmdl[b] = '0;
      for (int i = 0; i < DEPTH; i++) mdl[b][i] = '0;
    end

    // reset state
    rst = 1'b1;
    op(2'b00, 1'b0, '0, '0, '0, "reset");
    rst = 1'b0;

    // fill pass on bank0, then read every word back one cycle after its address
    for (int a = 0; a < DEPTH; a++) op(2'b01, 1'b1, AW'(a), 4'hF, DW'(a) ^ 16'hA5A5, "fill_wr");
    for (int a = 0; a < DEPTH; a++) op(2'b01, 1'b0, AW'(a), 4'h0, '0, "fill_rd");
    expect_const("fill_last", dout0, 16'h3FFF ^ 16'hA5A5);

    // nibble mask merge
    op(2'b01, 1'b1, 14'd5, 4'hF, 16'h1234, "nib_wr_full");
    op(2'b01, 1'b1, 14'd5, 4'b0101, 16'hABCD, "nib_wr_mask");
    op(2'b01, 1'b0, 14'd5, 4'h0, '0, "nib_rd");
    expect_const("nib_merge", dout0, 16'h1B3D);
    op(2'b01, 1'b1, 14'd5, 4'h0, 16'hFFFF, "nib_wr_nomask");
    op(2'b01, 1'b0, 14'd5, 4'h0, '0, "nib_rd_nomask");
    expect_const("nib_nomask", dout0, 16'h1B3D);

    // chip select: deselected write is dropped, opposite banks with shared bus
    op(2'b00, 1'b1, 14'd7, 4'hF, 16'hBEEF, "cs0_wr");
    op(2'b00, 1'b0, 14'd7, 4'h0, '0, "cs0_hold");
    op(2'b10, 1'b1, 14'd7, 4'hF, 16'hBEEF, "bank1_wr");
    op(2'b11, 1'b0, 14'd7, 4'h0, '0, "bank_rd");
    expect_const("bank0_7", dout0, 16'h0007 ^ 16'hA5A5);
    expect_const("bank1_7", dout1, 16'hBEEF);

    // reset clears dataout only, and blocks the write presented with it
    op(2'b01, 1'b1, 14'd9, 4'hF, 16'h1234, "rst_wr");
    op(2'b01, 1'b0, 14'd9, 4'h0, '0, "rst_rd0");
    rst = 1'b1;
    op(2'b01, 1'b1, 14'd9, 4'hF, 16'hFFFF, "rst_cycle");
    expect_const("rst_zero", dout0, 16'h0000);
    rst = 1'b0;
    op(2'b01, 1'b0, 14'd9, 4'h0, '0, "rst_reread");
    expect_const("rst_intact", dout0, 16'h1234);

    // back-to-back reads, no bubbles
    op(2'b11, 1'b0, 14'd0, 4'h0, '0, "pipe0");
    op(2'b11, 1'b0, 14'd1, 4'h0, '0, "pipe1");
    expect_const("pipe1_val", dout0, 16'h0001 ^ 16'hA5A5);
    op(2'b11, 1'b0, 14'd2, 4'h0, '0, "pipe2");

    // low-power controls (ignored unless SPRAM_LOWPOWER_EN)
    sleep = 1'b1;
    op(2'b01, 1'b1, 14'd5, 4'hF, 16'h7777, "sleep_wr");
    op(2'b01, 1'b0, 14'd5, 4'h0, '0, "sleep_rd");
    sleep = 1'b0;
    op(2'b01, 1'b0, 14'd9, 4'h0, '0, "post_sleep_rd");
    standby = 1'b1;
    op(2'b01, 1'b0, 14'd5, 4'h0, '0, "standby_rd");
    standby = 1'b0;
    poweroff = 1'b0;
    op(2'b11, 1'b0, 14'd9, 4'h0, '0, "poweroff");
    poweroff = 1'b1;
    op(2'b01, 1'b0, 14'd9, 4'h0, '0, "post_off_rd9");
    op(2'b11, 1'b0, 14'd7, 4'h0, '0, "post_off_rd7");
`ifdef SPRAM_LOWPOWER_EN
    expect_const("off_lost", dout1, 16'h0000);
`else
    expect_const("off_ignored", dout1, 16'hBEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
